// File: rtl/hz_pkg.sv
// hz_pkg: shared constants and helpers for the 1/2 Hz tick generator
package hz_pkg;
  localparam int CLK_FREQ_HZ_DEF = 50000000;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int HALF2_DEF = CLK_FREQ_HZ_DEF / 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int half2(input int freq);
    return freq / 4;
  endfunction
endpackage

// File: rtl/dip_debounce.sv
// dip_debounce: 2-flop synchronizer plus stable-count debouncer for a raw switch
module dip_debounce
  import hz_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic GPIO_DIP1,
  output logic GPIO_DIP1_DB
);
  localparam int CW = clog2(DB_CYCLES + 1);
  logic s1_q, s2_q, db_q, db_d, settle;
  logic [CW-1:0] cnt_q, cnt_d;
  // output follows only after the new level has been seen for DB_CYCLES+1 evaluations
  always_comb begin
    settle = (s2_q != db_q) && (cnt_q == CW'(DB_CYCLES));
    cnt_d = (s2_q == db_q || settle) ? '0 : cnt_q + 1'b1;
    db_d = settle ? s2_q : db_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= GPIO_DIP1;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end
  assign GPIO_DIP1_DB = db_q;
endmodule

// File: rtl/hz_tick_gen.sv
// hz_tick_gen: phase-aligned 2 Hz / 1 Hz square waves plus debounced DIP select
module hz_tick_gen
  import hz_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic GPIO_DIP1,
  output logic CLK2HZ,
  output logic CLK1HZ,
  output logic GPIO_DIP1_DB,
  output logic TICK2HZ
);
  localparam int HALF2 = half2(CLK_FREQ_HZ);
  localparam int CW = clog2(HALF2);
  logic [CW-1:0] cnt_q, cnt_d;
  logic clk2_q, clk2_d, clk1_q, clk1_d, tick_q, tick_d, term;
  // 1 Hz toggles only when 2 Hz rises, so both rising edges coincide
  always_comb begin
    term = EN && (cnt_q == CW'(HALF2 - 1));
    cnt_d = term ? '0 : (EN ? cnt_q + 1'b1 : cnt_q);
    clk2_d = clk2_q ^ term;
    clk1_d = clk1_q ^ (term & ~clk2_q);
    tick_d = term;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      clk2_q <= 1'b0;
      clk1_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk2_q <= clk2_d;
      clk1_q <= clk1_d;
      tick_q <= tick_d;
    end
  end
  dip_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .CLK(CLK),
    .RST(RST),
    .GPIO_DIP1(GPIO_DIP1),
    .GPIO_DIP1_DB(GPIO_DIP1_DB)
  );
  assign CLK2HZ = clk2_q;
  assign CLK1HZ = clk1_q;
  assign TICK2HZ = tick_q;
endmodule

// File: tb/tb_hz_tick_gen.sv
// tb_hz_tick_gen: directed bench with a per-cycle behavioural model of hz_tick_gen
module tb_hz_tick_gen;
  localparam int FREQ = 16;
  localparam int H = FREQ / 4;
  localparam int DB = 5;
  logic CLK, RST, EN, GPIO_DIP1;
  logic CLK2HZ, CLK1HZ, GPIO_DIP1_DB, TICK2HZ;
  int errors, checks, ec, n, guard;
  bit m_tick, m_db, chk_en, v, stable;
  bit q[$];
  hz_tick_gen #(.CLK_FREQ_HZ(FREQ), .DB_CYCLES(DB)) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .GPIO_DIP1(GPIO_DIP1),
    .CLK2HZ(CLK2HZ),
    .CLK1HZ(CLK1HZ),
    .GPIO_DIP1_DB(GPIO_DIP1_DB),
    .TICK2HZ(TICK2HZ)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", name, act, exp, ec, $time);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #2;
    ec++;
  endtask
  function automatic bit m_clk2();
    return bit'((n / H) % 2);
  endfunction
  function automatic bit m_clk1();
    return bit'(((n / H + 1) / 2) % 2);
  endfunction
  initial begin
    errors = 0;
    checks = 0;
    ec = 0;
    chk_en = 0;
    RST = 1'b1;
    EN = 1'b0;
    GPIO_DIP1 = 1'b0;
    fork
      // model: n counts enabled edges; the switch output adopts a level once the
      // sample taken two edges earlier and the DB before it all agree and differ from it
      forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
          n = 0;
          m_tick = 0;
          m_db = 0;
          q.delete();
          for (int i = 0; i < DB + 3; i++) q.push_back(1'b0);
        end else begin
          m_tick = 0;
          if (EN) begin
            n++;
            m_tick = (n % H == 0);
          end
          q.push_back(GPIO_DIP1);
          v = q[q.size() - 3];
          stable = (v != m_db);
          for (int k = 0; k <= DB; k++) if (q[q.size() - 3 - k] != v) stable = 0;
          if (stable) m_db = v;
        end
      end
      forever begin
        @(negedge CLK);
        if (chk_en) begin
          chk("model_clk2", CLK2HZ, m_clk2());
          chk("model_clk1", CLK1HZ, m_clk1());
          chk("model_tick", TICK2HZ, m_tick);
          chk("model_db", GPIO_DIP1_DB, m_db);
        end
      end
    join_none
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_clk2", CLK2HZ, 1'b0);
    chk("rst_clk1", CLK1HZ, 1'b0);
    chk("rst_tick", TICK2HZ, 1'b0);
    chk("rst_db", GPIO_DIP1_DB, 1'b0);
    chk_en = 1;
    RST = 1'b0;
    EN = 1'b1;
    ec = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("run_tick", TICK2HZ, (i % 4 == 0));
      if (i == 3) begin chk("e3_clk2", CLK2HZ, 1'b0); chk("e3_clk1", CLK1HZ, 1'b0); end
      if (i == 4) begin chk("e4_clk2", CLK2HZ, 1'b1); chk("e4_clk1", CLK1HZ, 1'b1); end
      if (i == 8) begin chk("e8_clk2", CLK2HZ, 1'b0); chk("e8_clk1", CLK1HZ, 1'b1); end
      if (i == 12) begin chk("e12_clk2", CLK2HZ, 1'b1); chk("e12_clk1", CLK1HZ, 1'b0); end
      if (i == 16) begin chk("e16_clk2", CLK2HZ, 1'b0); chk("e16_clk1", CLK1HZ, 1'b0); end
      if (i == 20) begin chk("e20_clk2", CLK2HZ, 1'b1); chk("e20_clk1", CLK1HZ, 1'b1); end
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    ec = 0;
    repeat (6) step();
    EN = 1'b0;
    for (int i = 7; i <= 16; i++) begin
      step();
      chk("hold_tick", TICK2HZ, 1'b0);
      if (i == 10 || i == 16) begin
        chk("hold_clk2", CLK2HZ, 1'b1);
        chk("hold_clk1", CLK1HZ, 1'b1);
      end
    end
    EN = 1'b1;
    step();
    chk("resume17_clk2", CLK2HZ, 1'b1);
    chk("resume17_tick", TICK2HZ, 1'b0);
    step();
    chk("resume18_clk2", CLK2HZ, 1'b0);
    chk("resume18_clk1", CLK1HZ, 1'b1);
    chk("resume18_tick", TICK2HZ, 1'b1);
    GPIO_DIP1 = 1'b1;
    repeat (3) step();
    GPIO_DIP1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch_db", GPIO_DIP1_DB, 1'b0);
    end
    chk("glitch_cnt_zero", dut.u_db.cnt_q == 0, 1'b1);
    GPIO_DIP1 = 1'b1;
    step();
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("latency_db", GPIO_DIP1_DB, (j == 7));
    end
    guard = 0;
    while (((n / H) % 4) != 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("find_state_bound", guard < 20, 1'b1);
    chk("pre_rst_clk2", CLK2HZ, 1'b1);
    chk("pre_rst_clk1", CLK1HZ, 1'b1);
    chk("pre_rst_db", GPIO_DIP1_DB, 1'b1);
    RST = 1'b1;
    #1;
    chk("async_clk2", CLK2HZ, 1'b0);
    chk("async_clk1", CLK1HZ, 1'b0);
    chk("async_tick", TICK2HZ, 1'b0);
    chk("async_db", GPIO_DIP1_DB, 1'b0);
    step();
    RST = 1'b0;
    ec = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) chk("post_e3_clk2", CLK2HZ, 1'b0);
      if (i == 4) begin
        chk("post_e4_clk2", CLK2HZ, 1'b1);
        chk("post_e4_clk1", CLK1HZ, 1'b1);
        chk("post_e4_tick", TICK2HZ, 1'b1);
      end
      if (i == 7) chk("post_e7_db", GPIO_DIP1_DB, 1'b0);
      if (i == 8) begin
        chk("same_edge_db", GPIO_DIP1_DB, 1'b1);
        chk("same_edge_clk2", CLK2HZ, 1'b0);
        chk("same_edge_clk1", CLK1HZ, 1'b1);
        chk("same_edge_tick", TICK2HZ, 1'b1);
      end
    end
    repeat (2) step();
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
